// File: rtl/powlib_cntr.sv
// Loadable W-bit counter with constant or dynamic step; priority clr > ld > adv > hold.
// Latency: one cycle from any strobe to cntr. No backpressure: every strobe is acted on when sampled.
module powlib_cntr #(
    parameter int           W    = 8,
    parameter logic [W-1:0] X    = 1,
    parameter logic [W-1:0] INIT = 0,
    parameter int           ELD  = 1,
    parameter int           EDX  = 0,
    parameter int           EAR  = 1
) (
    input  logic         clk,
    input  logic         rst,
    output logic [W-1:0] cntr,
    input  logic [W-1:0] nval,
    input  logic         adv,
    input  logic         ld,
    input  logic         clr,
    input  logic [W-1:0] dx
);

    logic [W-1:0] step;
    logic         ld_eff;
    logic [W-1:0] cntr_nxt;

    // Feature enables are elaboration-time constants, so the unused path folds away.
    assign step   = (EDX != 0) ? dx : X;
    assign ld_eff = (ELD != 0) && ld;

    always_comb begin
        cntr_nxt = cntr;
        if (clr) begin
            cntr_nxt = INIT;
        end else if (ld_eff) begin
            cntr_nxt = nval;
        end else if (adv) begin
            cntr_nxt = cntr + step;
        end
    end

    generate
        if (EAR != 0) begin : g_async_rst
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cntr <= INIT;
                end else begin
                    cntr <= cntr_nxt;
                end
            end
        end else begin : g_sync_rst
            always_ff @(posedge clk) begin
                if (!rst) begin
                    cntr <= INIT;
                end else begin
                    cntr <= cntr_nxt;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_powlib_cntr.sv
// Randomised and directed stimulus against three counter builds, checked by a queue-based scoreboard.
module tb_powlib_cntr;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] nval = 8'd0;
    logic       adv = 1'b0;
    logic       ld = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] dx = 8'd0;
    logic [7:0] cntr0, cntr1, cntr2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] e0;
        logic [7:0] e1;
        logic [7:0] e2;
    } exp_t;
    exp_t sb_q[$];

    // Reference state for each build.
    logic [7:0] m0 = 8'd0;
    logic [7:0] m1 = 8'd10;
    logic [7:0] m2 = 8'd0;

    always #5 clk = ~clk;

    // u0: default up-counter, async reset.
    powlib_cntr u0 (
        .clk(clk), .rst(rst), .cntr(cntr0), .nval(nval),
        .adv(adv), .ld(ld), .clr(clr), .dx(dx)
    );

    // u1: dynamic step, load disabled, synchronous reset, INIT=10.
    powlib_cntr #(.W(8), .X(8'd5), .INIT(8'd10), .ELD(0), .EDX(1), .EAR(0)) u1 (
        .clk(clk), .rst(rst), .cntr(cntr1), .nval(nval),
        .adv(adv), .ld(ld), .clr(clr), .dx(dx)
    );

    // u2: down-counter (X = -1), async reset.
    powlib_cntr #(.W(8), .X(8'hFF), .INIT(8'd0)) u2 (
        .clk(clk), .rst(rst), .cntr(cntr2), .nval(nval),
        .adv(adv), .ld(ld), .clr(clr), .dx(dx)
    );

    function automatic logic [7:0] ref_next(input logic [7:0] cur, input logic r, input logic c,
                                            input logic l, input logic a, input logic [7:0] nv,
                                            input logic [7:0] stp, input bit eld,
                                            input logic [7:0] init);
        int sum;
        if (!r) return init;
        if (c) return init;
        if (eld && l) return nv;
        if (a) begin
            sum = (int'(cur) + int'(stp)) % 256;
            return 8'(sum);
        end
        return cur;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs; the expected post-edge values go to the scoreboard.
    task automatic drive(input logic r, input logic c, input logic l, input logic a,
                         input logic [7:0] nv, input logic [7:0] d);
        exp_t e;
        logic prev_rst;
        @(negedge clk);
        prev_rst = rst;
        rst = r; clr = c; ld = l; adv = a; nval = nv; dx = d;
        if (prev_rst && !r) begin
            #1;
            check("async_rst_u0", cntr0, 8'd0);
            check("async_rst_u2", cntr2, 8'd0);
            check("sync_rst_wait_u1", cntr1, m1);
        end
        m0 = ref_next(m0, r, c, l, a, nv, 8'd1,  1'b1, 8'd0);
        m1 = ref_next(m1, r, c, l, a, nv, d,     1'b0, 8'd10);
        m2 = ref_next(m2, r, c, l, a, nv, 8'hFF, 1'b1, 8'd0);
        e.e0 = m0; e.e1 = m1; e.e2 = m2;
        sb_q.push_back(e);
    endtask

    // Monitor: sample away from the active edge and compare against the oldest expectation.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("cntr_u0", cntr0, e.e0);
            check("cntr_u1", cntr1, e.e1);
            check("cntr_u2", cntr2, e.e2);
        end
    end

    initial begin
        // Reset, then 300 advances: u0 wraps 255->0, u2 counts down from 255.
        drive(0, 0, 0, 0, 8'd0, 8'd0);
        drive(0, 0, 0, 1, 8'd0, 8'd1);
        for (int i = 0; i < 300; i++) drive(1, 0, 0, 1, 8'd0, 8'd1);

        // Priority: bring u0 to 5, then clr+ld+adv, then ld+adv, then hold.
        drive(1, 1, 0, 0, 8'd0, 8'd0);
        for (int i = 0; i < 5; i++) drive(1, 0, 0, 1, 8'd0, 8'd0);
        drive(1, 1, 1, 1, 8'd99, 8'd3);
        drive(1, 0, 1, 1, 8'd99, 8'd3);
        drive(1, 0, 0, 0, 8'd0, 8'd3);
        drive(1, 0, 0, 0, 8'd0, 8'd3);

        // Dynamic step on u1: 10 -> 17 -> 24 -> 18.
        drive(1, 1, 0, 0, 8'd0, 8'd0);
        drive(1, 0, 0, 1, 8'd0, 8'd7);
        drive(1, 0, 0, 1, 8'd0, 8'd7);
        drive(1, 0, 0, 1, 8'd0, 8'd250);

        // Load-disabled u1 ignores ld/nval and just advances.
        drive(1, 0, 1, 1, 8'h80, 8'd1);

        // Async reset mid-count: load 42 then pull reset low between edges.
        drive(1, 0, 1, 0, 8'd42, 8'd0);
        drive(0, 0, 0, 1, 8'd0, 8'd1);
        drive(0, 0, 1, 1, 8'd77, 8'd1);
        drive(1, 0, 0, 1, 8'd0, 8'd1);

        // Randomised traffic.
        for (int i = 0; i < 2000; i++) begin
            logic r, c, l, a;
            r = ($urandom_range(99) >= 2);
            c = ($urandom_range(99) < 8);
            l = ($urandom_range(99) < 20);
            a = ($urandom_range(99) < 65);
            drive(r, c, l, a, 8'($urandom), 8'($urandom));
        end

        drive(1, 0, 0, 0, 8'd0, 8'd0);
        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
